// File: rtl/chronologic_pkg.sv
// Shared types and defaults for the chronologic exclusivity monitor.
package chronologic_pkg;

   localparam int unsigned CNT_W_DEF = 32;

   // Bit 1 flags a&b, bit 0 flags a&c.
   typedef enum logic [1:0] {
      CAUSE_NONE = 2'b00,
      CAUSE_AC   = 2'b01,
      CAUSE_AB   = 2'b10,
      CAUSE_ABC  = 2'b11
   } cause_t;

endpackage

// File: rtl/chronologic_sat_cnt.sv
// Saturating up-counter with synchronous clear; clear beats increment.
module chronologic_sat_cnt #(
   parameter int unsigned W = 32
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         clr,
   input  logic         inc,
   output logic [W-1:0] cnt_o
);

   logic [W-1:0] cnt_q;
   logic [W-1:0] cnt_d;

   always_comb begin
      cnt_d = cnt_q;
      if (clr) begin
         cnt_d = '0;
      end else if (inc && (cnt_q != {W{1'b1}})) begin
         cnt_d = cnt_q + W'(1);
      end
   end

   always_ff @(posedge clk) begin
      if (rst) cnt_q <= '0;
      else     cnt_q <= cnt_d;
   end

   assign cnt_o = cnt_q;

endmodule

// File: rtl/chronologic.sv
// Mutual-exclusivity monitor: flags cycles where signal_a overlaps signal_b or
// signal_c, with pass/fail pulses, counters, sticky error and first-fail stamp.
module chronologic
   import chronologic_pkg::*;
#(
   parameter int unsigned CNT_W = CNT_W_DEF
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             en,
   input  logic             clr,
   input  logic             signal_a,
   input  logic             signal_b,
   input  logic             signal_c,
   output logic             pass_o,
   output logic             fail_o,
   output logic [1:0]       cause_o,
   output logic             err_sticky_o,
   output logic [CNT_W-1:0] pass_cnt_o,
   output logic [CNT_W-1:0] fail_cnt_o,
   output logic [CNT_W-1:0] cyc_cnt_o,
   output logic [CNT_W-1:0] first_fail_o
);

   logic             pass_q, pass_d;
   logic             fail_q, fail_d;
   cause_t           cause_q, cause_d;
   logic             sticky_q, sticky_d;
   logic [CNT_W-1:0] cyc_q, cyc_d;
   logic [CNT_W-1:0] first_q, first_d;
   logic             viol_c;

   // A cleared cycle still pulses but never counts or arms the sticky flag.
   always_comb begin
      pass_d   = 1'b0;
      fail_d   = 1'b0;
      cause_d  = CAUSE_NONE;
      sticky_d = sticky_q;
      first_d  = first_q;
      cyc_d    = cyc_q + CNT_W'(1);
      viol_c   = signal_a & (signal_b | signal_c);

      if (en) begin
         pass_d  = ~viol_c;
         fail_d  = viol_c;
         cause_d = cause_t'({signal_a & signal_b, signal_a & signal_c});
      end

      if (clr) begin
         sticky_d = 1'b0;
         first_d  = '0;
      end else if (fail_d && !sticky_q) begin
         sticky_d = 1'b1;
         first_d  = cyc_q;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         pass_q   <= 1'b0;
         fail_q   <= 1'b0;
         cause_q  <= CAUSE_NONE;
         sticky_q <= 1'b0;
         cyc_q    <= '0;
         first_q  <= '0;
      end else begin
         pass_q   <= pass_d;
         fail_q   <= fail_d;
         cause_q  <= cause_d;
         sticky_q <= sticky_d;
         cyc_q    <= cyc_d;
         first_q  <= first_d;
      end
   end

   chronologic_sat_cnt #(.W(CNT_W)) u_pass_cnt (
      .clk   (clk),
      .rst   (rst),
      .clr   (clr),
      .inc   (pass_d & ~clr),
      .cnt_o (pass_cnt_o)
   );

   chronologic_sat_cnt #(.W(CNT_W)) u_fail_cnt (
      .clk   (clk),
      .rst   (rst),
      .clr   (clr),
      .inc   (fail_d & ~clr),
      .cnt_o (fail_cnt_o)
   );

   assign pass_o       = pass_q;
   assign fail_o       = fail_q;
   assign cause_o      = cause_q;
   assign err_sticky_o = sticky_q;
   assign cyc_cnt_o    = cyc_q;
   assign first_fail_o = first_q;

endmodule

// File: tb/tb_chronologic.sv
// Bench for chronologic: a 32-bit and a 4-bit instance share stimulus and are
// checked every cycle against an abstract model, plus literal anchor values.
module tb_chronologic;

   logic clk = 1'b0;
   logic rst, en, clr, sa, sb, sc;

   logic        p32, f32, s32;
   logic [1:0]  c32;
   logic [31:0] pc32, fc32, cy32, ff32;
   logic        p4, f4, s4;
   logic [1:0]  c4;
   logic [3:0]  pc4, fc4, cy4, ff4;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   chronologic #(.CNT_W(32)) u_dut32 (
      .clk(clk), .rst(rst), .en(en), .clr(clr),
      .signal_a(sa), .signal_b(sb), .signal_c(sc),
      .pass_o(p32), .fail_o(f32), .cause_o(c32), .err_sticky_o(s32),
      .pass_cnt_o(pc32), .fail_cnt_o(fc32), .cyc_cnt_o(cy32), .first_fail_o(ff32)
   );

   chronologic #(.CNT_W(4)) u_dut4 (
      .clk(clk), .rst(rst), .en(en), .clr(clr),
      .signal_a(sa), .signal_b(sb), .signal_c(sc),
      .pass_o(p4), .fail_o(f4), .cause_o(c4), .err_sticky_o(s4),
      .pass_cnt_o(pc4), .fail_cnt_o(fc4), .cyc_cnt_o(cy4), .first_fail_o(ff4)
   );

   // Abstract model: unbounded counts, saturated or wrapped per instance width.
   longint m_cyc = 0, m_first = 0;
   longint m_pass32 = 0, m_fail32 = 0, m_pass4 = 0, m_fail4 = 0;
   bit     m_pass = 0, m_fail = 0, m_sticky = 0, m_valid = 0;
   logic [1:0] m_cause = 2'b00;

   always @(posedge clk) begin
      bit viol;
      m_valid = 1'b1;
      if (rst) begin
         m_cyc = 0; m_first = 0; m_pass32 = 0; m_fail32 = 0;
         m_pass4 = 0; m_fail4 = 0; m_pass = 0; m_fail = 0;
         m_sticky = 0; m_cause = 2'b00;
      end else begin
         viol    = sa && (sb || sc);
         m_pass  = en && !viol;
         m_fail  = en && viol;
         m_cause = en ? {sa & sb, sa & sc} : 2'b00;
         if (clr) begin
            m_pass32 = 0; m_fail32 = 0; m_pass4 = 0; m_fail4 = 0;
            m_sticky = 0; m_first = 0;
         end else begin
            if (m_pass && m_pass32 < 64'd4294967295) m_pass32++;
            if (m_fail && m_fail32 < 64'd4294967295) m_fail32++;
            if (m_pass && m_pass4 < 15) m_pass4++;
            if (m_fail && m_fail4 < 15) m_fail4++;
            if (m_fail && !m_sticky) begin
               m_sticky = 1'b1;
               m_first  = m_cyc;
            end
         end
         m_cyc++;
      end
   end

   task automatic chk(input string name, input longint act, input longint exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
      end
   endtask

   always @(negedge clk) begin
      if (m_valid) begin
         chk("pass32",   longint'(p32),  longint'(m_pass));
         chk("fail32",   longint'(f32),  longint'(m_fail));
         chk("cause32",  longint'(c32),  longint'(m_cause));
         chk("sticky32", longint'(s32),  longint'(m_sticky));
         chk("pcnt32",   longint'(pc32), m_pass32);
         chk("fcnt32",   longint'(fc32), m_fail32);
         chk("cyc32",    longint'(cy32), m_cyc & 64'hFFFF_FFFF);
         chk("first32",  longint'(ff32), m_first & 64'hFFFF_FFFF);
         chk("pass4",    longint'(p4),   longint'(m_pass));
         chk("fail4",    longint'(f4),   longint'(m_fail));
         chk("cause4",   longint'(c4),   longint'(m_cause));
         chk("sticky4",  longint'(s4),   longint'(m_sticky));
         chk("pcnt4",    longint'(pc4),  m_pass4);
         chk("fcnt4",    longint'(fc4),  m_fail4);
         chk("cyc4",     longint'(cy4),  m_cyc & 64'hF);
         chk("first4",   longint'(ff4),  m_first & 64'hF);
      end
   end

   // Called at a negedge: drive, let one edge happen, return at the next negedge.
   task automatic step(input logic r, input logic e, input logic c, input logic [2:0] abc);
      rst = r; en = e; clr = c;
      {sa, sb, sc} = abc;
      @(posedge clk);
      @(negedge clk);
   endtask

   initial begin
      rst = 1'b1; en = 1'b0; clr = 1'b0; sa = 1'b0; sb = 1'b0; sc = 1'b0;
      @(negedge clk);
      step(1'b1, 1'b0, 1'b0, 3'b111);
      step(1'b1, 1'b0, 1'b0, 3'b111);
      chk("rst_cyc",    longint'(cy32), 0);
      chk("rst_sticky", longint'(s32),  0);

      // Sweep: sample k sees cyc_cnt = k.
      for (int i = 0; i < 8; i++) begin
         step(1'b0, 1'b1, 1'b0, 3'(i));
         if (i == 5) chk("sweep5_cause", longint'(c32), 1);
         if (i == 6) chk("sweep6_cause", longint'(c32), 2);
         if (i == 7) chk("sweep7_cause", longint'(c32), 3);
         if (i == 4) chk("sweep4_pass",  longint'(p32), 1);
      end
      chk("sweep_pcnt",   longint'(pc32), 5);
      chk("sweep_fcnt",   longint'(fc32), 3);
      chk("sweep_sticky", longint'(s32),  1);
      chk("sweep_first",  longint'(ff32), 5);

      // b&c without a is legal.
      for (int i = 0; i < 4; i++) step(1'b0, 1'b1, 1'b0, 3'b011);
      chk("bc_pcnt", longint'(pc32), 9);
      chk("bc_fcnt", longint'(fc32), 3);

      // Disabled checks.
      for (int i = 0; i < 3; i++) step(1'b0, 1'b0, 1'b0, 3'b111);
      chk("en0_cyc",  longint'(cy32), 15);
      chk("en0_fail", longint'(f32),  0);
      chk("en0_fcnt", longint'(fc32), 3);

      // Clear (sample 15), then fail at cycles 20 and 30.
      step(1'b0, 1'b0, 1'b1, 3'b000);
      chk("clr_pcnt",  longint'(pc32), 0);
      chk("clr_first", longint'(ff32), 0);
      for (int i = 0; i < 4; i++) step(1'b0, 1'b1, 1'b0, 3'b100);
      step(1'b0, 1'b1, 1'b0, 3'b101);
      for (int i = 0; i < 9; i++) step(1'b0, 1'b1, 1'b0, 3'b000);
      step(1'b0, 1'b1, 1'b0, 3'b110);
      chk("ret_first", longint'(ff32), 20);
      chk("ret_fcnt",  longint'(fc32), 2);
      chk("ret_pcnt",  longint'(pc32), 13);
      chk("ret_first4", longint'(ff4), 4);

      // Clear in the same cycle as a failing check.
      step(1'b0, 1'b1, 1'b1, 3'b110);
      chk("clrchk_fail",   longint'(f32),  1);
      chk("clrchk_cause",  longint'(c32),  2);
      chk("clrchk_fcnt",   longint'(fc32), 0);
      chk("clrchk_sticky", longint'(s32),  0);

      // Saturation on the 4-bit instance.
      for (int i = 0; i < 20; i++) step(1'b0, 1'b1, 1'b0, 3'b010);
      chk("sat_pcnt4",  longint'(pc4),  15);
      chk("sat_pcnt32", longint'(pc32), 20);

      // Reset mid-stream with a violating sample.
      step(1'b1, 1'b1, 1'b0, 3'b111);
      chk("mrst_fail",  longint'(f32),  0);
      chk("mrst_cause", longint'(c32),  0);
      chk("mrst_pcnt4", longint'(pc4),  0);
      chk("mrst_cyc",   longint'(cy32), 0);
      step(1'b0, 1'b1, 1'b0, 3'b111);
      chk("post_first", longint'(ff32), 0);
      step(1'b0, 1'b1, 1'b0, 3'b000);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
